rf_write_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline writeback stage and the long-latency multiply/divide unit (MDU). It keeps a per-register busy scoreboard for MDU results still in flight, and a one-entry buffer for MDU results that lose arbitration. A starvation counter stalls the pipeline when the buffer cannot drain. It sits between the WB stage, the MDU and the register file write port (`WE3/A3/WD3`).

---
 rtl/rf_write_arbiter.sv | 137 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// WB stage (always wins) and the MDU (one-entry buffer when it loses).
// Tracks in-flight MDU destinations in a busy scoreboard and raises a
// registered stall request when a buffered result has waited too long.
// Optional feature: define RF_ARB_BYPASS_EN to let an MDU result that meets
// an empty buffer and an idle WB stage write straight through in its
// handshake cycle.
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic [31:0] busy,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  buf_state_e  state_q, state_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall_q, stall_d;

  logic        wb_eff, mdu_eff, full, drain, drop, bypass, capture;
  logic [31:0] set_mask, clr_mask;

  // Saturating increment for the 4-bit starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign mdu_ready = (state_q == BUF_EMPTY);
  assign busy      = busy_q;
  assign stall_req = stall_q;

  // Classify this cycle's requests and the buffer's fate.
  always_comb begin
    wb_eff  = wb_we && (wb_rd != 5'd0);
    mdu_eff = mdu_valid && (mdu_rd != 5'd0);
    full    = (state_q == BUF_FULL);
    drain   = full && !wb_eff;
    // A younger WB write to the buffered register makes the buffered value dead.
    drop    = full && wb_eff && (wb_rd == buf_rd_q);
`ifdef RF_ARB_BYPASS_EN
    bypass  = !full && mdu_eff && !wb_eff;
`else
    bypass  = 1'b0;
`endif
    // A handshake with rd == 0 is accepted but never captured.
    capture = !full && mdu_eff && !bypass;
  end

  // Write-port mux: WB, then buffer, then (optionally) direct MDU bypass.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!rst) begin
      if (wb_eff) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end else if (full) begin
        rf_we    = 1'b1;
        rf_waddr = buf_rd_q;
        rf_wdata = buf_data_q;
      end else if (bypass) begin
        rf_we    = 1'b1;
        rf_waddr = mdu_rd;
        rf_wdata = mdu_data;
      end
    end
  end

  // Next buffer, scoreboard and starvation state.
  always_comb begin
    state_d    = state_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    if (drain || drop) begin
      state_d = BUF_EMPTY;
    end else if (capture) begin
      state_d    = BUF_FULL;
      buf_rd_d   = mdu_rd;
      buf_data_d = mdu_data;
    end

    clr_mask = 32'd0;
    set_mask = 32'd0;
    if (drain || drop) clr_mask[buf_rd_q] = 1'b1;
    if (bypass)        clr_mask[mdu_rd]   = 1'b1;
    if (iss_valid && (iss_rd != 5'd0)) set_mask[iss_rd] = 1'b1;
    // Set is applied after clear so a same-cycle reissue keeps the bit.
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;

    cnt_d   = (full && !drain && !drop) ? sat_inc(cnt_q) : 4'd0;
    stall_d = (cnt_d >= LIMIT);
  end

  // Control state with synchronous reset; a reset drops any buffered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      busy_q  <= 32'd0;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Buffer payload; only meaningful while the buffer is FULL.
  always_ff @(posedge clk) begin
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a behavioural model predicts each
// cycle's status and write-port traffic; a negedge monitor checks the DUT.
module tb_rf_write_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, wb_we, mdu_valid, iss_valid;
  logic [4:0]  wb_rd, mdu_rd, iss_rd;
  logic [31:0] wb_data, mdu_data;
  logic        mdu_ready, stall_req, rf_we;
  logic [31:0] busy, rf_wdata;
  logic [4:0]  rf_waddr;

  // Pending stimulus for the next cycle.
  logic        p_rst, p_wb_we, p_mdu_valid, p_iss_valid;
  logic [4:0]  p_wb_rd, p_mdu_rd, p_iss_rd;
  logic [31:0] p_wb_data, p_mdu_data;

  // Reference model state.
  wr_t m_buf[$];
  bit  m_busy[32];
  int  m_wait;
  bit  m_stall;

  // Expectations for the current cycle.
  wr_t         exp_q[$];
  logic        exp_ready, exp_stall, exp_we;
  logic [31:0] exp_busy;
  bit          chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy(busy), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    p_rst = 0; p_wb_we = 0; p_wb_rd = 0; p_wb_data = 0;
    p_mdu_valid = 0; p_mdu_rd = 0; p_mdu_data = 0;
    p_iss_valid = 0; p_iss_rd = 0;
  endtask

  // Apply pending stimulus for one cycle and advance the reference model.
  task automatic step();
    bit  wb_w, mdu_w, has_buf, byp, retire;
    wr_t w;
    @(posedge clk); #1;
    rst = p_rst; wb_we = p_wb_we; wb_rd = p_wb_rd; wb_data = p_wb_data;
    mdu_valid = p_mdu_valid; mdu_rd = p_mdu_rd; mdu_data = p_mdu_data;
    iss_valid = p_iss_valid; iss_rd = p_iss_rd;

    has_buf   = (m_buf.size() != 0);
    exp_ready = !has_buf;
    exp_stall = m_stall;
    for (int i = 0; i < 32; i++) exp_busy[i] = m_busy[i];

    wb_w  = p_wb_we && (p_wb_rd != 0);
    mdu_w = p_mdu_valid && (p_mdu_rd != 0);
    byp   = 0;
`ifdef RF_ARB_BYPASS_EN
    byp   = !has_buf && mdu_w && !wb_w;
`endif

    exp_we = 0;
    if (!p_rst) begin
      if (wb_w) begin
        w.rd = p_wb_rd; w.data = p_wb_data; exp_q.push_back(w); exp_we = 1;
      end else if (has_buf) begin
        exp_q.push_back(m_buf[0]); exp_we = 1;
      end else if (byp) begin
        w.rd = p_mdu_rd; w.data = p_mdu_data; exp_q.push_back(w); exp_we = 1;
      end
    end

    if (p_rst) begin
      m_buf.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_wait  = 0;
      m_stall = 0;
    end else begin
      retire = has_buf && (!wb_w || p_wb_rd == m_buf[0].rd);
      if (retire) m_busy[m_buf[0].rd] = 0;
      if (byp) m_busy[p_mdu_rd] = 0;
      if (p_iss_valid && p_iss_rd != 0) m_busy[p_iss_rd] = 1;
      if (has_buf && !retire) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
      else m_wait = 0;
      m_stall = (m_wait >= LIMIT);
      if (retire) m_buf.delete();
      else if (!has_buf && mdu_w && !byp) begin
        w.rd = p_mdu_rd; w.data = p_mdu_data; m_buf.push_back(w);
      end
    end
  endtask

  // Monitor: status every cycle, write traffic popped from the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      wr_t e;
      check("mdu_ready", {31'd0, mdu_ready}, {31'd0, exp_ready});
      check("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
      check("busy", busy, exp_busy);
      check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rf_write: unexpected write x%0d=%h (t=%0t)", rf_waddr, rf_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
          check("rf_wdata", rf_wdata, e.data);
        end
      end else begin
        check("idle_waddr", {27'd0, rf_waddr}, 32'd0);
        check("idle_wdata", rf_wdata, 32'd0);
      end
    end
  end

  initial begin
    m_wait = 0; m_stall = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    idle_in();
    rst = 1; wb_we = 0; wb_rd = 0; wb_data = 0; mdu_valid = 0; mdu_rd = 0;
    mdu_data = 0; iss_valid = 0; iss_rd = 0;

    // Reset, then idle.
    p_rst = 1; step();
    step();
    chk_en = 1;
    idle_in(); step(); step();

    // Issue to x5, result three cycles later with WB idle.
    p_iss_valid = 1; p_iss_rd = 5; step();
    idle_in(); step(); step(); step();
    p_mdu_valid = 1; p_mdu_rd = 5; p_mdu_data = 32'hDEADBEEF; step();
    idle_in(); step(); step();

    // Result for x7 starved by six WB writes to x3.
    p_iss_valid = 1; p_iss_rd = 7; step();
    idle_in();
    p_mdu_valid = 1; p_mdu_rd = 7; p_mdu_data = 32'h7777_0007;
    p_wb_we = 1; p_wb_rd = 3;
    for (int i = 0; i < 6; i++) begin
      p_wb_data = 32'h3000_0000 + i; step();
      p_mdu_valid = 0;
    end
    idle_in(); step(); step(); step();

    // WAW drop: buffered x9 overwritten by a younger WB write.
    p_iss_valid = 1; p_iss_rd = 9; step();
    idle_in();
    p_mdu_valid = 1; p_mdu_rd = 9; p_mdu_data = 32'h9999_9999;
    p_wb_we = 1; p_wb_rd = 3; p_wb_data = 32'h33; step();
    idle_in(); p_wb_we = 1; p_wb_rd = 9; p_wb_data = 32'h1; step();
    idle_in(); step(); step();

    // Reissue to x4 in the drain cycle of x4; then an rd=0 result.
    p_iss_valid = 1; p_iss_rd = 4; step();
    idle_in();
    p_mdu_valid = 1; p_mdu_rd = 4; p_mdu_data = 32'h4444;
    p_wb_we = 1; p_wb_rd = 3; p_wb_data = 32'h34; step();
    idle_in(); p_iss_valid = 1; p_iss_rd = 4; step();
    idle_in(); step();
    p_mdu_valid = 1; p_mdu_rd = 0; p_mdu_data = 32'hBAD0; step();
    idle_in(); step();

    // Reset while the buffer holds x8.
    p_iss_valid = 1; p_iss_rd = 8; step();
    idle_in();
    p_mdu_valid = 1; p_mdu_rd = 8; p_mdu_data = 32'h8888;
    p_wb_we = 1; p_wb_rd = 3; p_wb_data = 32'h35; step();
    idle_in(); p_rst = 1; step();
    idle_in(); step(); step();

    // Randomized traffic; the pipeline honours stall_req most of the time.
    for (int n = 0; n < 3000; n++) begin
      p_rst       = ($urandom_range(0, 299) == 0);
      p_wb_we     = ($urandom_range(0, 9) < 6);
      if (m_stall && $urandom_range(0, 3) != 0) p_wb_we = 0;
      p_wb_rd     = 5'($urandom_range(0, 11));
      p_wb_data   = $urandom;
      p_mdu_valid = ($urandom_range(0, 2) == 0);
      p_mdu_rd    = 5'($urandom_range(0, 11));
      p_mdu_data  = $urandom;
      p_iss_valid = ($urandom_range(0, 3) == 0);
      p_iss_rd    = 5'($urandom_range(0, 11));
      step();
    end
    idle_in(); step(); step();
    @(negedge clk); #1;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
